// File: rtl/looper_ctrl_pkg.sv
// Shared definitions for the looper boot controller: FSM encoding and
// internal counter widths.
package looper_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Width of the extern_pc_en hold counter (PC_HOLD is at most 15)
  localparam int HOLD_W = 4;

  // Width of the flush timer (FLUSH_TO is at most 65535)
  localparam int FTMR_W = 16;

endpackage

// File: rtl/looper_dncnt.sv
// Loadable down-counter with a terminal-count flag. The count stops at
// zero and never wraps; tc is high while the count is zero.
module looper_dncnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] count;

  // Load takes priority over decrement; decrement stops at zero.
  // NOTE: state updates in clocked blocks use <= so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Terminal count is a pure decode of the register.
  assign tc = (count == '0);

endmodule

// File: rtl/looper_boot_ctrl.sv
// Boot/run/flush sequencer for top_module_looper: loads the boot PC, lets
// the core run for a programmed number of cycles, flushes the data cache
// and reports completion or flush timeout.
module looper_boot_ctrl
  import looper_ctrl_pkg::*;
#(
  parameter int PC_W     = 16,
  parameter int CNT_W    = 20,
  parameter int PC_HOLD  = 2,
  parameter int FLUSH_TO = 2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  boot_pc,
  input  logic [CNT_W-1:0] run_len,
  input  logic             abort,
  input  logic             flush_done,
  output logic [PC_W-1:0]  extern_pc,
  output logic             extern_pc_en,
  output logic             flush_cache,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [PC_W-1:0]     pc_d;
  logic                pc_en_d;
  logic                flush_d;
  logic                busy_d;
  logic                done_d;
  logic                tmo_d;
  logic [CNT_W-1:0]    cyc_d;

  logic                start_ok;
  logic                load_last;
  logic                run_dec;
  logic                run_tc;
  logic                ft_load;
  logic                ft_dec;
  logic                ft_tc;

  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
  assign load_last = (state_q == LOAD) && (hold_q == '0);

  // The run counter is loaded with run_len on start and also steps on the
  // final LOAD edge. At that edge tc flags run_len == 0; in RUN it then
  // holds remaining-1, so tc marks the edge at which remaining is 1.
  assign run_dec = load_last || (state_q == RUN);

  looper_dncnt #(
    .W (CNT_W)
  ) u_run_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .load_val (run_len),
    .dec      (run_dec),
    .tc       (run_tc)
  );

  // The flush timer is parked at FLUSH_TO-1 outside FLUSH and counts down
  // inside it; reaching zero equals an up-count reaching FLUSH_TO-1.
  assign ft_load = (state_q != FLUSH);
  assign ft_dec  = (state_q == FLUSH);

  looper_dncnt #(
    .W (FTMR_W)
  ) u_flush_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ft_load),
    .load_val (FTMR_W'(FLUSH_TO - 1)),
    .dec      (ft_dec),
    .tc       (ft_tc)
  );

  // Next-state and next-output decode; every output is a registered copy.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pc_d    = extern_pc;
    pc_en_d = extern_pc_en;
    flush_d = flush_cache;
    busy_d  = busy;
    done_d  = done;
    tmo_d   = timeout;
    cyc_d   = cycle_cnt;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d    = boot_pc;
          pc_en_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
          cyc_d   = '0;
          hold_d  = HOLD_W'(PC_HOLD - 1);
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (abort) begin
          pc_en_d = 1'b0;
          flush_d = 1'b1;
          state_d = FLUSH;
        end else if (hold_q == '0) begin
          pc_en_d = 1'b0;
          if (run_tc) begin
            flush_d = 1'b1;
            state_d = FLUSH;
          end else begin
            state_d = RUN;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end

      RUN: begin
        cyc_d = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
        if (abort || run_tc) begin
          flush_d = 1'b1;
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        // flush_done wins over a coinciding timeout.
        if (flush_done || ft_tc) begin
          flush_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tmo_d   = !flush_done;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, hold counter and output registers; reset clears all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      extern_pc    <= '0;
      extern_pc_en <= 1'b0;
      flush_cache  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      cycle_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      extern_pc    <= pc_d;
      extern_pc_en <= pc_en_d;
      flush_cache  <= flush_d;
      busy         <= busy_d;
      done         <= done_d;
      timeout      <= tmo_d;
      cycle_cnt    <= cyc_d;
    end
  end

endmodule

// File: tb/tb_looper_boot_ctrl.sv
// Self-checking bench for looper_boot_ctrl: a table of run scenarios whose
// expected waveform figures go through a scoreboard queue, plus hand-written
// sequences for reset state and asynchronous reset mid-flush.
module tb_looper_boot_ctrl;
  import looper_ctrl_pkg::*;

  localparam int PC_W     = 16;
  localparam int CNT_W    = 20;
  localparam int PC_HOLD  = 2;
  localparam int FLUSH_TO = 8;
  localparam int BUDGET   = 3000;
  localparam int NVEC     = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [PC_W-1:0]  boot_pc;
  logic [CNT_W-1:0] run_len;
  logic             abort;
  logic             flush_done;
  logic [PC_W-1:0]  extern_pc;
  logic             extern_pc_en;
  logic             flush_cache;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;

  int total = 0;
  int bad   = 0;

  // Scenario record: stimulus plus the waveform figures it must produce.
  typedef struct {
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] rl;
    int               abort_k;   // first observed cycle to drive abort (3 cycles), -1 none
    int               fd_delay;  // cycles after flush_cache rise to pulse flush_done, -1 never
    int               noise_k;   // cycle to pulse start+flush_done while busy, -1 none
    int               en_cyc;    // cycles extern_pc_en is high
    int               gap;       // cycles from extern_pc_en fall to flush_cache rise
    int               fl_cyc;    // cycles flush_cache is high
    int               cnt;       // final cycle_cnt
    int               tmo;       // final timeout
  } vec_t;

  typedef struct {
    int pc;
    int en_cyc;
    int gap;
    int fl_cyc;
    int cnt;
    int tmo;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];

  looper_boot_ctrl #(
    .PC_W     (PC_W),
    .CNT_W    (CNT_W),
    .PC_HOLD  (PC_HOLD),
    .FLUSH_TO (FLUSH_TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .boot_pc      (boot_pc),
    .run_len      (run_len),
    .abort        (abort),
    .flush_done   (flush_done),
    .extern_pc    (extern_pc),
    .extern_pc_en (extern_pc_en),
    .flush_cache  (flush_cache),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .cycle_cnt    (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one scenario from IDLE/DONE to done, measuring the waveform.
  task automatic run_case(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    int   k;
    int   en_cnt;
    int   fl_cnt;
    int   en_fall;
    int   f_rise;
    bit   finished;

    e.pc     = 32'(v.pc);
    e.en_cyc = v.en_cyc;
    e.gap    = v.gap;
    e.fl_cyc = v.fl_cyc;
    e.cnt    = v.cnt;
    e.tmo    = v.tmo;
    sb_q.push_back(e);

    boot_pc = v.pc;
    run_len = v.rl;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;

    en_cnt = 0; fl_cnt = 0; en_fall = -1; f_rise = -1; finished = 1'b0;
    for (k = 0; k < BUDGET; k++) begin
      if (k == 0) begin
        check($sformatf("v%0d_accept_pc", idx), 32'(extern_pc), 32'(v.pc));
        check($sformatf("v%0d_accept_done", idx), 32'(done), 32'd0);
        check($sformatf("v%0d_accept_tmo", idx), 32'(timeout), 32'd0);
        check($sformatf("v%0d_accept_busy", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d_accept_cnt", idx), 32'(cycle_cnt), 32'd0);
      end
      if (done && k > 0) begin
        finished = 1'b1;
        break;
      end
      if (extern_pc_en) en_cnt++;
      else if (en_fall < 0) en_fall = k;
      if (flush_cache) begin
        fl_cnt++;
        if (f_rise < 0) f_rise = k;
      end
      abort      = (v.abort_k >= 0) && (k >= v.abort_k) && (k < v.abort_k + 3);
      flush_done = ((f_rise >= 0) && (v.fd_delay >= 0) && (k == f_rise + v.fd_delay))
                   || (k == v.noise_k);
      start      = (k == v.noise_k);
      boot_pc    = (k == v.noise_k) ? ~v.pc : v.pc;
      run_len    = (k == v.noise_k) ? CNT_W'(3) : v.rl;
      @(negedge clk);
    end
    abort = 1'b0; flush_done = 1'b0; start = 1'b0;

    got = sb_q.pop_front();
    if (!finished) begin
      check($sformatf("v%0d_done_within_budget", idx), 32'(done), 32'd1);
      do_reset();
    end else begin
      check($sformatf("v%0d_en_cycles", idx), 32'(en_cnt), 32'(got.en_cyc));
      check($sformatf("v%0d_gap", idx), 32'(f_rise - en_fall), 32'(got.gap));
      check($sformatf("v%0d_flush_cycles", idx), 32'(fl_cnt), 32'(got.fl_cyc));
      check($sformatf("v%0d_cycle_cnt", idx), 32'(cycle_cnt), 32'(got.cnt));
      check($sformatf("v%0d_timeout", idx), 32'(timeout), 32'(got.tmo));
      check($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
      check($sformatf("v%0d_pc_held", idx), 32'(extern_pc), 32'(got.pc));
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_done_sticky", idx), 32'(done), 32'd1);
      check($sformatf("v%0d_tmo_sticky", idx), 32'(timeout), 32'(got.tmo));
    end
  endtask

  initial begin
    int  w;
    bit  seen;

    //         pc       rl    abort fd  noise en gap fl cnt tmo
    vecs[0] = '{16'h0040, 20'd10,   -1,  3, -1, 2, 10, 4, 10, 0}; // normal run
    vecs[1] = '{16'h0080, 20'd0,    -1,  2, -1, 2,  0, 3,  0, 0}; // zero-length run
    vecs[2] = '{16'h0100, 20'd1000,  6,  5, -1, 2,  5, 6,  5, 0}; // abort in RUN cycle 5, held into FLUSH
    vecs[3] = '{16'h0200, 20'd4,    -1, -1, -1, 2,  4, 8,  4, 1}; // flush timeout
    vecs[4] = '{16'h1234, 20'd3,    -1,  0, -1, 2,  3, 1,  3, 0}; // start in DONE after timeout
    vecs[5] = '{16'h0300, 20'd20,   -1,  2,  5, 2, 20, 3, 20, 0}; // start and flush_done while in RUN
    vecs[6] = '{16'h0400, 20'd50,    0,  1, -1, 1,  0, 2,  0, 0}; // abort in LOAD
    vecs[7] = '{16'h0500, 20'd1,    -1,  7, -1, 2,  1, 8,  1, 0}; // flush_done coincides with timeout

    start = 1'b0; boot_pc = '0; run_len = '0; abort = 1'b0; flush_done = 1'b0;
    do_reset();

    check("rst_extern_pc", 32'(extern_pc), 32'd0);
    check("rst_extern_pc_en", 32'(extern_pc_en), 32'd0);
    check("rst_flush_cache", 32'(flush_cache), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      run_case(i, vecs[i]);
    end

    // Asynchronous reset in the middle of FLUSH.
    boot_pc = 16'h0600; run_len = 20'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (w = 0; w < 50; w++) begin
      if (flush_cache) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("arst_reached_flush", 32'(seen), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flush_cache", 32'(flush_cache), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_extern_pc_en", 32'(extern_pc_en), 32'd0);
    check("arst_extern_pc", 32'(extern_pc), 32'd0);
    check("arst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_case(NVEC, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
